// File: rtl/ram_pkg.sv
// Shared widths and FSM encoding for the line RAM responder.
// RAM_RANGE_CHECK_EN adds the sticky range_err output on the top.
package ram_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        RESP     = 2'd2,
        WAIT_LOW = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/ram_line_array.sv
// Single-port line storage: synchronous write, combinational read.
// Per-line valid bits make reset-cleared lines read back as zero.
module ram_line_array
    import ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (we_i) begin
            vld_q[addr_i] <= 1'b1;
        end
    end

    assign rdata_o = vld_q[addr_i] ? mem_q[addr_i] : '0;

endmodule

// File: rtl/line_ram_responder.sv
// Fixed-latency line RAM answering cache requests with a one-cycle pulse.
// RAM_RANGE_CHECK_EN: flag and suppress accesses above the RAM size.
module line_ram_responder
    import ram_pkg::*;
#(
    parameter int LINE_DEPTH = 256,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_cache_to_ram,
    input  logic              write_cache_to_ram,
    input  logic [ADDR_W-1:0] address_cache_to_ram,
    input  logic [LINE_W-1:0] data_cache_to_ram_i,
    output logic              response_ram_to_cache,
    output logic [LINE_W-1:0] data_ram_to_cache_o
`ifdef RAM_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);

    localparam int IDX_W  = $clog2(LINE_DEPTH);
    localparam int HI_LSB = OFFSET_W + IDX_W;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic               oor_q;
    logic [LINE_W-1:0]  line_q;
    logic               resp_q;
    logic [LINE_W-1:0]  rdata_q;

    logic [IDX_W-1:0]   idx_d;
    logic               oor_d;
    logic               mem_we;
    logic [LINE_W-1:0]  mem_rdata;
    logic               unused_addr;

    assign idx_d = address_cache_to_ram[HI_LSB-1:OFFSET_W];

`ifdef RAM_RANGE_CHECK_EN
    assign oor_d       = |address_cache_to_ram[ADDR_W-1:HI_LSB];
    assign unused_addr = ^address_cache_to_ram[OFFSET_W-1:0];
`else
    assign oor_d       = 1'b0;
    assign unused_addr = ^{address_cache_to_ram[ADDR_W-1:HI_LSB],
                           address_cache_to_ram[OFFSET_W-1:0]};
`endif

    // Commit happens on the edge leaving RESP, so reset in RESP drops it.
    assign mem_we = (state_q == RESP) && write_q && !oor_q;

    ram_line_array #(
        .DEPTH (LINE_DEPTH),
        .AW    (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (line_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            line_q  <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable_cache_to_ram) begin
                        idx_q   <= idx_d;
                        write_q <= write_cache_to_ram;
                        oor_q   <= oor_d;
                        line_q  <= data_cache_to_ram_i;
                        cnt_q   <= lat_load(LATENCY);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        rdata_q <= (write_q || oor_q) ? '0 : mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    state_q <= enable_cache_to_ram ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!enable_cache_to_ram) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && enable_cache_to_ram && oor_d) begin
            err_q <= 1'b1;
        end
    end

    assign range_err = err_q;
`endif

    assign response_ram_to_cache = resp_q;
    assign data_ram_to_cache_o   = rdata_q;

endmodule

// File: tb/tb_line_ram_responder.sv
// Self-checking bench for line_ram_responder against a line-array model.
// Build with +define+RAM_RANGE_CHECK_EN to exercise range_err.
module tb_line_ram_responder;

    localparam int LINE_DEPTH = 256;
    localparam int LATENCY    = 4;
    localparam int IW         = $clog2(LINE_DEPTH);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic         resp;
    logic [255:0] rdata;
`ifdef RAM_RANGE_CHECK_EN
    logic         range_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [255:0] model [LINE_DEPTH];
    bit           model_err;

    always #5 clk = ~clk;

    line_ram_responder #(
        .LINE_DEPTH (LINE_DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (en),
        .write_cache_to_ram    (wr),
        .address_cache_to_ram  (addr),
        .data_cache_to_ram_i   (wdata),
        .response_ram_to_cache (resp),
        .data_ram_to_cache_o   (rdata)
`ifdef RAM_RANGE_CHECK_EN
        ,
        .range_err             (range_err)
`endif
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINE_DEPTH; i++) model[i] = '0;
        model_err = 1'b0;
    endfunction

    // Returns the line a read should see; writes update the model.
    function automatic logic [255:0] model_op(input logic w,
                                              input logic [31:0] a,
                                              input logic [255:0] d);
        int  li;
        bit  oor;
        li = int'((a >> 5) % LINE_DEPTH);
`ifdef RAM_RANGE_CHECK_EN
        oor = (a >> (5 + IW)) != 0;
`else
        oor = 1'b0;
`endif
        model_err = model_err | oor;
        if (w) begin
            if (!oor) model[li] = d;
            return '0;
        end
        return oor ? '0 : model[li];
    endfunction

    // One request; latency counts cycles from the accept edge (cycle 1 is
    // the cycle that edge starts). Response is expected in cycle LATENCY+1.
    task automatic do_op(input logic w, input logic [31:0] a,
                         input logic [255:0] d, input int hold,
                         input bit scramble, output int lat,
                         output int pulses, output logic [255:0] rd,
                         output int leak);
        lat = 0;
        pulses = 0;
        rd = '0;
        leak = 0;
        @(negedge clk);
        en = 1'b1;
        wr = w;
        addr = a;
        wdata = d;
        @(posedge clk);
        for (int k = 1; k <= LATENCY + hold + 4; k++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    rd = rdata;
                end
            end else if (rdata !== '0) begin
                leak++;
            end
            if (scramble && k == 2) begin
                en = 1'b0;
                wr = ~w;
                addr = $urandom;
                wdata = rand_line();
            end
            if (lat != 0 && k == lat + hold) en = 1'b0;
        end
        en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (resp !== 1'b0) begin
            fails++;
            $display("FAIL reset_resp: got %b want 0", resp);
        end
        tests++;
        if (rdata !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", rdata);
        end
`ifdef RAM_RANGE_CHECK_EN
        tests++;
        if (range_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_range_err: got %b want 0", range_err);
        end
`endif
    endtask

    task automatic test_unwritten_read();
        int lat, pulses, leak;
        logic [255:0] rd;
        do_op(1'b0, 32'h1000, '0, 0, 1'b0, lat, pulses, rd, leak);
        tests++;
        if (lat != LATENCY + 1 || pulses != 1) begin
            fails++;
            $display("FAIL unwritten_resp: lat %0d pulses %0d want %0d 1",
                     lat, pulses, LATENCY + 1);
        end
        tests++;
        if (rd !== model_op(1'b0, 32'h1000, '0) || rd !== '0) begin
            fails++;
            $display("FAIL unwritten_data: got %h want 0", rd);
        end
    endtask

    task automatic test_write_read();
        int lat, pulses, leak;
        logic [255:0] rd, exp;
        logic [255:0] pat;
        pat = {32{8'hA5}};
        do_op(1'b1, 32'h40, pat, 1, 1'b0, lat, pulses, rd, leak);
        void'(model_op(1'b1, 32'h40, pat));
        tests++;
        if (lat != LATENCY + 1) begin
            fails++;
            $display("FAIL wr_latency: got %0d want %0d", lat, LATENCY + 1);
        end
        tests++;
        if (rd !== '0 || leak != 0) begin
            fails++;
            $display("FAIL wr_data_out: got %h leak %0d want 0", rd, leak);
        end
        do_op(1'b0, 32'h40, '0, 0, 1'b0, lat, pulses, rd, leak);
        exp = model_op(1'b0, 32'h40, '0);
        tests++;
        if (rd !== exp || lat != LATENCY + 1) begin
            fails++;
            $display("FAIL rd_a5: got %h lat %0d want %h lat %0d",
                     rd, lat, exp, LATENCY + 1);
        end
        tests++;
        if (leak != 0) begin
            fails++;
            $display("FAIL rd_leak: got %0d nonzero cycles want 0", leak);
        end
    endtask

    task automatic test_hold_enable();
        int lat, pulses, leak;
        logic [255:0] rd, d, exp;
        d = rand_line();
        do_op(1'b1, 32'h60, d, 3, 1'b0, lat, pulses, rd, leak);
        void'(model_op(1'b1, 32'h60, d));
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL hold_pulses: got %0d want 1", pulses);
        end
        do_op(1'b0, 32'h60, '0, 0, 1'b0, lat, pulses, rd, leak);
        exp = model_op(1'b0, 32'h60, '0);
        tests++;
        if (lat != LATENCY + 1 || rd !== exp) begin
            fails++;
            $display("FAIL hold_next_req: lat %0d data %h want %0d %h",
                     lat, rd, LATENCY + 1, exp);
        end
    endtask

    task automatic test_mid_busy_change();
        int lat, pulses, leak;
        logic [255:0] rd, d, exp;
        d = rand_line();
        do_op(1'b1, 32'h2A0, d, 0, 1'b1, lat, pulses, rd, leak);
        void'(model_op(1'b1, 32'h2A0, d));
        tests++;
        if (lat != LATENCY + 1 || pulses != 1) begin
            fails++;
            $display("FAIL busy_change_resp: lat %0d pulses %0d want %0d 1",
                     lat, pulses, LATENCY + 1);
        end
        do_op(1'b0, 32'h2A0, '0, 0, 1'b0, lat, pulses, rd, leak);
        exp = model_op(1'b0, 32'h2A0, '0);
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL busy_change_data: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_wrap_or_range();
        int lat, pulses, leak;
        logic [255:0] rd, a_pat, b_pat, exp;
        a_pat = rand_line();
        b_pat = ~a_pat;
        do_op(1'b1, 32'h0, a_pat, 0, 1'b0, lat, pulses, rd, leak);
        void'(model_op(1'b1, 32'h0, a_pat));
        do_op(1'b1, 32'h2000, b_pat, 0, 1'b0, lat, pulses, rd, leak);
        void'(model_op(1'b1, 32'h2000, b_pat));
        tests++;
        if (lat != LATENCY + 1 || pulses != 1) begin
            fails++;
            $display("FAIL hi_addr_resp: lat %0d pulses %0d want %0d 1",
                     lat, pulses, LATENCY + 1);
        end
`ifdef RAM_RANGE_CHECK_EN
        tests++;
        if (range_err !== 1'b1) begin
            fails++;
            $display("FAIL hi_addr_range_err: got %b want 1", range_err);
        end
`endif
        do_op(1'b0, 32'h0, '0, 0, 1'b0, lat, pulses, rd, leak);
        exp = model_op(1'b0, 32'h0, '0);
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL hi_addr_line0: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_random();
        int lat, pulses, leak;
        logic [255:0] rd, d, exp;
        logic [31:0] a;
        logic w;
        int bad_t, bad_d;
        bad_t = 0;
        bad_d = 0;
        for (int n = 0; n < 40; n++) begin
            w = 1'(($urandom_range(0, 1)));
            a = ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 7) << (5 + IW));
            d = rand_line();
            do_op(w, a, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  lat, pulses, rd, leak);
            exp = model_op(w, a, d);
            if (lat != LATENCY + 1 || pulses != 1 || leak != 0) bad_t++;
            if (rd !== exp) begin
                bad_d++;
                if (bad_d == 1)
                    $display("FAIL rand_data: op %0d addr %h got %h want %h",
                             n, a, rd, exp);
            end
        end
        tests++;
        if (bad_t != 0) begin
            fails++;
            $display("FAIL rand_timing: got %0d bad ops want 0", bad_t);
        end
        tests++;
        if (bad_d != 0) begin
            fails++;
            $display("FAIL rand_mismatches: got %0d bad ops want 0", bad_d);
        end
`ifdef RAM_RANGE_CHECK_EN
        tests++;
        if (range_err !== model_err) begin
            fails++;
            $display("FAIL rand_range_err: got %b want %b", range_err, model_err);
        end
`endif
    endtask

    task automatic test_reset_in_resp();
        int lat, pulses, leak;
        logic [255:0] rd, exp;
        @(negedge clk);
        en = 1'b1;
        wr = 1'b1;
        addr = 32'h80;
        wdata = rand_line();
        @(posedge clk);
        repeat (LATENCY) @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        tests++;
        if (resp !== 1'b0 || rdata !== '0) begin
            fails++;
            $display("FAIL rst_in_resp: resp %b data %h want 0 0", resp, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        do_op(1'b0, 32'h80, '0, 0, 1'b0, lat, pulses, rd, leak);
        exp = model_op(1'b0, 32'h80, '0);
        tests++;
        if (rd !== exp || lat != LATENCY + 1) begin
            fails++;
            $display("FAIL rst_in_resp_read: got %h lat %0d want %h lat %0d",
                     rd, lat, exp, LATENCY + 1);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_unwritten_read();
        test_write_read();
        test_hold_enable();
        test_mid_busy_change();
        test_wrap_or_range();
        test_random();
        test_reset_in_resp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
